// File: rtl/reset_sequencer.sv
// Purpose: releases NUM_STAGES reset domains one at a time, in ascending order, once the PLL is stably locked.
// Latency: stage 0 releases LOCK_FILTER+STAGE_DELAY cycles after lock; each later stage STAGE_DELAY cycles after the previous ack.
// Backpressure: waits on stage_ready of the current stage for up to TIMEOUT cycles, then faults until soft_req.
//
// Ports:
//   clk          system clock
//   res_n        asynchronous active-low reset
//   pll_locked   PLL lock indication, filtered before sequencing starts
//   soft_req     one-cycle pulse that restarts the whole sequence (also clears a fault)
//   stage_ready  per-stage acknowledge, only the bit of the stage being sequenced is looked at
//   stage_rst_n  registered per-stage active-low resets
//   seq_done     every stage released and acknowledged
//   seq_fault    sticky acknowledge-timeout flag
//   fault_stage  index of the stage that timed out
//   busy         sequencing in progress (WAIT_LOCK, HOLD, WAIT_ACK)
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int LOCK_FILTER = 16,
  parameter int STAGE_DELAY = 255,
  parameter int TIMEOUT     = 4095
) (
  input  logic                          clk,
  input  logic                          res_n,
  input  logic                          pll_locked,
  input  logic                          soft_req,
  input  logic [NUM_STAGES-1:0]         stage_ready,
  output logic [NUM_STAGES-1:0]         stage_rst_n,
  output logic                          seq_done,
  output logic                          seq_fault,
  output logic [$clog2(NUM_STAGES)-1:0] fault_stage,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_STAGES);
  localparam int LF_W  = $clog2(LOCK_FILTER + 1);

  // Terminal counts: a counter holding N-1 on an edge means N cycles have elapsed.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [LF_W-1:0]  LF_LAST  = LF_W'(LOCK_FILTER - 1);
  localparam logic [11:0]      DLY_LAST = 12'(STAGE_DELAY - 1);
  localparam logic [11:0]      TO_LAST  = 12'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LOCK,
    S_HOLD,
    S_WAIT_ACK,
    S_DONE,
    S_FAULT
  } state_e;

  state_e                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [11:0]             dly_cnt_q;
  logic [LF_W-1:0]         lock_cnt_q;
  logic [NUM_STAGES-1:0]   stage_rst_n_q;
  logic                    seq_done_q;
  logic                    seq_fault_q;
  logic [IDX_W-1:0]        fault_stage_q;
  logic                    busy_q;

  logic [11:0]             dly_cnt_d;
  logic [LF_W-1:0]         lock_cnt_d;
  logic                    cur_ready;
  logic                    soft_restart;
  logic                    lock_lost;

  always_comb begin
    // Saturating increments: the counters never wrap back to zero.
    dly_cnt_d    = (dly_cnt_q == 12'hFFF) ? dly_cnt_q : dly_cnt_q + 12'd1;
    lock_cnt_d   = (lock_cnt_q == '1) ? lock_cnt_q : lock_cnt_q + LF_W'(1);
    cur_ready    = stage_ready[idx_q];
    soft_restart = soft_req && (state_q != S_IDLE);
    // FAULT deliberately ignores the PLL; only soft_req leaves it.
    lock_lost    = !pll_locked &&
                   ((state_q == S_HOLD) || (state_q == S_WAIT_ACK) || (state_q == S_DONE));
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      dly_cnt_q     <= '0;
      lock_cnt_q    <= '0;
      stage_rst_n_q <= '0;
      seq_done_q    <= 1'b0;
      seq_fault_q   <= 1'b0;
      fault_stage_q <= '0;
      busy_q        <= 1'b0;
    end else if (soft_restart) begin
      // Takes priority over a simultaneous lock loss; also the only exit from FAULT.
      state_q       <= S_WAIT_LOCK;
      idx_q         <= '0;
      dly_cnt_q     <= '0;
      lock_cnt_q    <= '0;
      stage_rst_n_q <= '0;
      seq_done_q    <= 1'b0;
      seq_fault_q   <= 1'b0;
      fault_stage_q <= '0;
      busy_q        <= 1'b1;
    end else if (lock_lost) begin
      state_q       <= S_WAIT_LOCK;
      idx_q         <= '0;
      dly_cnt_q     <= '0;
      lock_cnt_q    <= '0;
      stage_rst_n_q <= '0;
      seq_done_q    <= 1'b0;
      busy_q        <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_WAIT_LOCK;
          busy_q  <= 1'b1;
        end
        S_WAIT_LOCK: begin
          if (!pll_locked) begin
            lock_cnt_q <= '0;
          end else if (lock_cnt_q == LF_LAST) begin
            state_q    <= S_HOLD;
            idx_q      <= '0;
            dly_cnt_q  <= '0;
            lock_cnt_q <= '0;
          end else begin
            lock_cnt_q <= lock_cnt_d;
          end
        end
        S_HOLD: begin
          if (dly_cnt_q == DLY_LAST) begin
            stage_rst_n_q[idx_q] <= 1'b1;
            state_q              <= S_WAIT_ACK;
            dly_cnt_q            <= '0;
          end else begin
            dly_cnt_q <= dly_cnt_d;
          end
        end
        S_WAIT_ACK: begin
          if (cur_ready) begin
            dly_cnt_q <= '0;
            if (idx_q == LAST_IDX) begin
              state_q    <= S_DONE;
              seq_done_q <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= S_HOLD;
            end
          end else if (dly_cnt_q == TO_LAST) begin
            state_q       <= S_FAULT;
            seq_fault_q   <= 1'b1;
            fault_stage_q <= idx_q;
            stage_rst_n_q <= '0;
            busy_q        <= 1'b0;
            dly_cnt_q     <= '0;
          end else begin
            dly_cnt_q <= dly_cnt_d;
          end
        end
        S_DONE: begin
          // Later drops of stage_ready are ignored; only lock loss or soft_req leave DONE.
        end
        S_FAULT: begin
        end
        default: begin
          state_q       <= S_IDLE;
          stage_rst_n_q <= '0;
          seq_done_q    <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign stage_rst_n = stage_rst_n_q;
  assign seq_done    = seq_done_q;
  assign seq_fault   = seq_fault_q;
  assign fault_stage = fault_stage_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Purpose: directed self-checking bench for reset_sequencer (4 stages, filter 4, delay 8, timeout 32).
// Latency: expected release/ack/fault cycle counts are hand-computed constants.
// Backpressure: stage_ready is driven by the bench two cycles after each observed release.
module tb_reset_sequencer;

  logic       clk;
  logic       res_n;
  logic       pll_locked;
  logic       soft_req;
  logic [3:0] stage_ready;
  logic [3:0] stage_rst_n;
  logic       seq_done;
  logic       seq_fault;
  logic [1:0] fault_stage;
  logic       busy;

  int vec_cnt    = 0;
  int miscmp_cnt = 0;
  int n;

  reset_sequencer #(
    .NUM_STAGES (4),
    .LOCK_FILTER(4),
    .STAGE_DELAY(8),
    .TIMEOUT    (32)
  ) dut (
    .clk        (clk),
    .res_n      (res_n),
    .pll_locked (pll_locked),
    .soft_req   (soft_req),
    .stage_ready(stage_ready),
    .stage_rst_n(stage_rst_n),
    .seq_done   (seq_done),
    .seq_fault  (seq_fault),
    .fault_stage(fault_stage),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: observed %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] rel_pat(input int k);
    case (k)
      0:       return 4'b0001;
      1:       return 4'b0011;
      2:       return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  // Counts falling edges until the selected condition holds; -1 if the budget runs out.
  // sel 0: stage_rst_n == pat, sel 1: seq_done, sel 2: seq_fault.
  task automatic wait_cond(input int sel, input logic [3:0] pat, input int limit, output int cnt);
    bit hit;
    hit = 1'b0;
    cnt = -1;
    for (int i = 1; i <= limit; i++) begin
      if (!hit) begin
        @(negedge clk);
        if ((sel == 0 && stage_rst_n === pat) ||
            (sel == 1 && seq_done === 1'b1) ||
            (sel == 2 && seq_fault === 1'b1)) begin
          hit = 1'b1;
          cnt = i;
        end
      end
    end
  endtask

  // Called right after stage 0 release is seen: acks stages 0..num-1, each two cycles after
  // its release, and checks the next release comes 8 cycles after HOLD entry (9 from the ack drive).
  task automatic ack_stages(input string tag, input int num);
    int c;
    for (int k = 0; k < num; k++) begin
      check_vec($sformatf("%s_busy_rel%0d", tag, k), busy, 1);
      repeat (2) @(negedge clk);
      stage_ready[k] = 1'b1;
      if (k == 3) begin
        wait_cond(1, 4'b0000, 10, c);
        check_vec($sformatf("%s_done_lat", tag), c, 1);
        check_vec($sformatf("%s_done_busy", tag), busy, 0);
        check_vec($sformatf("%s_done_rst", tag), stage_rst_n, 4'b1111);
      end else begin
        wait_cond(0, rel_pat(k + 1), 20, c);
        check_vec($sformatf("%s_rel%0d_lat", tag, k + 1), c, 9);
      end
    end
  endtask

  initial begin
    res_n       = 1'b0;
    pll_locked  = 1'b0;
    soft_req    = 1'b0;
    stage_ready = 4'b0000;

    // Reset values
    repeat (2) @(negedge clk);
    check_vec("rst_stage_rst_n", stage_rst_n, 0);
    check_vec("rst_seq_done", seq_done, 0);
    check_vec("rst_seq_fault", seq_fault, 0);
    check_vec("rst_fault_stage", fault_stage, 0);
    check_vec("rst_busy", busy, 0);

    // Nominal: IDLE edge + 4 lock edges + 8 hold edges -> stage 0 at edge 13
    res_n      = 1'b1;
    pll_locked = 1'b1;
    wait_cond(0, 4'b0001, 30, n);
    check_vec("nom_rel0_lat", n, 13);
    ack_stages("nom", 4);

    // Dropping an acknowledged ready in DONE has no effect
    stage_ready = 4'b0000;
    @(negedge clk);
    check_vec("ack_drop_done", seq_done, 1);
    check_vec("ack_drop_rst", stage_rst_n, 4'b1111);

    // Lock loss in DONE for one cycle
    pll_locked = 1'b0;
    @(negedge clk);
    check_vec("ll_rst", stage_rst_n, 0);
    check_vec("ll_done", seq_done, 0);
    check_vec("ll_busy", busy, 1);
    pll_locked = 1'b1;
    wait_cond(0, 4'b0001, 30, n);
    check_vec("ll_rel0_lat", n, 12);
    ack_stages("ll", 4);

    // Lock glitch: high 3, low 1, then high -> release 4+8 cycles after the final rise
    stage_ready = 4'b0000;
    pll_locked  = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    wait_cond(0, 4'b0001, 30, n);
    check_vec("gl_rel0_lat", n, 12);

    // Timeout on stage 2; stage 3 ready is set but must be ignored
    ack_stages("to", 2);
    stage_ready = 4'b1011;
    wait_cond(2, 4'b0000, 45, n);
    check_vec("to_lat", n, 32);
    check_vec("to_fault_stage", fault_stage, 2);
    check_vec("to_rst", stage_rst_n, 0);
    check_vec("to_busy", busy, 0);
    check_vec("to_done", seq_done, 0);

    // PLL toggle in FAULT changes nothing
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    repeat (2) @(negedge clk);
    check_vec("flt_pll_fault", seq_fault, 1);
    check_vec("flt_pll_stage", fault_stage, 2);
    check_vec("flt_pll_rst", stage_rst_n, 0);
    check_vec("flt_pll_busy", busy, 0);

    // Recovery via soft_req
    soft_req    = 1'b1;
    stage_ready = 4'b0000;
    @(negedge clk);
    soft_req = 1'b0;
    check_vec("rec_fault", seq_fault, 0);
    check_vec("rec_fault_stage", fault_stage, 0);
    check_vec("rec_busy", busy, 1);
    wait_cond(0, 4'b0001, 30, n);
    check_vec("rec_rel0_lat", n, 12);
    ack_stages("rec", 4);

    // Restart from DONE, then async reset in the middle of stage 1 HOLD
    soft_req    = 1'b1;
    stage_ready = 4'b0000;
    @(negedge clk);
    soft_req = 1'b0;
    check_vec("sr_done_clr", seq_done, 0);
    wait_cond(0, 4'b0001, 30, n);
    check_vec("sr_rel0_lat", n, 12);
    repeat (2) @(negedge clk);
    stage_ready[0] = 1'b1;
    repeat (4) @(negedge clk);
    check_vec("pre_ar_rst", stage_rst_n, 4'b0001);
    check_vec("pre_ar_busy", busy, 1);
    #2;
    res_n = 1'b0;
    #1;
    check_vec("ar_rst", stage_rst_n, 0);
    check_vec("ar_done", seq_done, 0);
    check_vec("ar_fault", seq_fault, 0);
    check_vec("ar_fault_stage", fault_stage, 0);
    check_vec("ar_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_STAGES, default 4: number of sequenced reset domains (2..8).
REQ-002 The block SHALL have parameter LOCK_FILTER, default 16: consecutive pll_locked-high cycles required before sequencing.
REQ-003 The block SHALL have parameter STAGE_DELAY, default 255: cycles each stage is held before release (1..4095).
REQ-004 The block SHALL have parameter TIMEOUT, default 4095: maximum cycles to wait for stage_ready after release (1..4095).
REQ-005 The block SHALL have port clk, input, 1: single system clock.
REQ-006 The block SHALL have port res_n, input, 1: reset, asynchronous, active-low.
REQ-007 The block SHALL have port pll_locked, input, 1: PLL lock indication, synchronous to clk.
REQ-008 The block SHALL have port soft_req, input, 1: one-cycle pulse requesting a full re-sequence.
REQ-009 The block SHALL have port stage_ready, input, NUM_STAGES: per-stage ready/ack, synchronous to clk.
REQ-010 The block SHALL have port stage_rst_n, output, NUM_STAGES: registered per-stage active-low resets.
REQ-011 The block SHALL have port seq_done, output, 1: all stages released and acknowledged.
REQ-012 The block SHALL have port seq_fault, output, 1: sticky timeout fault.
REQ-013 The block SHALL have port fault_stage, output, clog2(NUM_STAGES): index of the stage that timed out.
REQ-014 The block SHALL have port busy, output, 1: high in WAIT_LOCK, HOLD and WAIT_ACK.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT_LOCK, HOLD, WAIT_ACK, DONE and FAULT, plus a stage index idx, a 12-bit delay counter and a lock-filter counter.
REQ-016 IDLE SHALL transition unconditionally to WAIT_LOCK on the first clock edge after reset release.
REQ-017 WAIT_LOCK SHALL count consecutive pll_locked=1 cycles, reset the count on any pll_locked=0, and enter HOLD with idx=0 when the count reaches LOCK_FILTER.
REQ-018 HOLD SHALL count cycles from entry; stage_rst_n[idx] SHALL rise exactly STAGE_DELAY cycles after HOLD entry, coincident with entry to WAIT_ACK.
REQ-019 WAIT_ACK SHALL sample stage_ready[idx] from the first cycle in the state.
REQ-020 When stage_ready[idx]=1 in WAIT_ACK, the FSM SHALL enter DONE if idx=NUM_STAGES-1; otherwise it SHALL increment idx and enter HOLD.
REQ-021 If stage_ready[idx] stays 0 for TIMEOUT cycles in WAIT_ACK, the FSM SHALL enter FAULT, latch fault_stage=idx, set seq_fault=1 and drive all stage_rst_n to 0 on the next edge.
REQ-022 Released stages SHALL remain released while later stages sequence; release order SHALL be strictly index 0 first, ascending.
REQ-023 seq_done SHALL be 1 only in DONE; busy SHALL be 0 in IDLE, DONE and FAULT.
REQ-024 pll_locked=0 in HOLD, WAIT_ACK or DONE SHALL drive all stage_rst_n to 0 on the next edge, clear seq_done, clear the counters and return to WAIT_LOCK.
REQ-025 In FAULT, pll_locked SHALL be ignored; FAULT SHALL be left only via soft_req.
REQ-026 soft_req=1 in any state except IDLE SHALL drive all stage_rst_n to 0, clear seq_done, seq_fault and fault_stage, and enter WAIT_LOCK on the next edge.
REQ-027 When soft_req and pll_locked=0 occur in the same cycle, the soft_req action SHALL apply.
REQ-028 A stage_ready transition to 0 after acknowledgement SHALL be ignored.
REQ-029 stage_ready bits of non-current stages SHALL be ignored.
REQ-030 Counters SHALL saturate and never wrap.

Reset
REQ-031 While res_n=0, asynchronously: stage_rst_n=0 (all bits), seq_done=0, seq_fault=0, fault_stage=0, busy=0, state=IDLE, idx=0 and all counters=0.
REQ-032 Assertion of res_n mid-sequence SHALL immediately force the values in REQ-031, with no partial release retained.

Verification (bench: NUM_STAGES=4, LOCK_FILTER=4, STAGE_DELAY=8, TIMEOUT=32)
REQ-033 Nominal case: pll_locked=1 and each stage_ready asserted 2 cycles after its release -> stage_rst_n goes 0001, 0011, 0111, 1111 with releases 8 cycles after each HOLD entry, then seq_done=1 and busy=0.
REQ-034 Lock glitch: pll_locked high for 3 cycles, low for 1, then high -> the first release occurs 4+8 cycles after the final rise.
REQ-035 Timeout: stage_ready[2] held at 0 -> after 32 WAIT_ACK cycles seq_fault=1, fault_stage=2, stage_rst_n=0000; a later pll_locked toggle causes no change.
REQ-036 Recovery: soft_req pulse in FAULT -> seq_fault=0 and a full re-sequence completes to seq_done=1.
REQ-037 Lock loss in DONE: pll_locked=0 for 1 cycle -> stage_rst_n=0000 and seq_done=0 next edge, then re-sequence.
REQ-038 Async reset mid-HOLD of stage 1 -> outputs match REQ-031 without waiting for a clock edge.
